// File: rtl/prio_encoder_pipe_pkg.sv
// Shared constants and helpers for the pipelined priority encoder.
// Imported by the interface, the encode core and the pipeline top.
package prio_enc_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    // Index width, clamped to at least one bit so tiny N still yields a legal vector.
    function automatic int calc_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/prio_encoder_pipe_if.sv
// Request/result handshake bundle for prio_encoder_pipe.
// The producer and consumer sides share the master modport.
interface prio_encoder_pipe_if
    import prio_enc_pkg::*;
#(
    parameter int N = 8
);
    localparam int W = calc_w(N);

    logic [N-1:0] enc_req;
    logic         enc_mode_rr;
    logic         EN_enc;
    logic         RDY_enc;
    logic [W-1:0] out_idx;
    logic         out_none;
    logic         RDY_out;
    logic         EN_out;

    modport master (
        output enc_req, enc_mode_rr, EN_enc, EN_out,
        input  RDY_enc, out_idx, out_none, RDY_out
    );

    modport slave (
        input  enc_req, enc_mode_rr, EN_enc, EN_out,
        output RDY_enc, out_idx, out_none, RDY_out
    );

endinterface

// File: rtl/prio_encoder_pipe_core.sv
// Combinational encoder: rotate the request by the search start, pick the winner,
// then rotate the winning position back into an absolute line index.
module prio_enc_core
    import prio_enc_pkg::*;
#(
    parameter int N = 8,
    parameter int W = calc_w(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    input  logic         mode_rr,
    output logic [W-1:0] idx,
    output logic         none
);
    localparam logic [W:0] N_EXT = (W+1)'(N);

    // Modulo-N addition; both operands are always below N.
    function automatic logic [W-1:0] wrap_add(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= N_EXT) s = s - N_EXT;
        return s[W-1:0];
    endfunction

    logic [W-1:0] shift;
    logic [W-1:0] pos;
    logic [N-1:0] rot;

    always_comb begin
        shift = (mode_rr == MODE_FIXED) ? '0 : ptr;
        rot   = '0;
        for (int i = 0; i < N; i++) rot[i] = req[wrap_add(W'(i), shift)];

        // Round-robin takes the first set bit after the pointer, fixed takes the top one.
        pos = '0;
        if (mode_rr == MODE_RR) begin
            for (int i = N - 1; i >= 0; i--) if (rot[i]) pos = W'(i);
        end else begin
            for (int i = 0; i < N; i++) if (rot[i]) pos = W'(i);
        end

        none = ~|req;
        idx  = none ? '0 : wrap_add(pos, shift);
    end

endmodule

// File: rtl/prio_encoder_pipe.sv
// Two-stage priority encoder: stage 1 captures a request, stage 2 holds the result
// until the consumer takes it. A full pipe still moves one result per cycle.
module prio_encoder_pipe
    import prio_enc_pkg::*;
#(
    parameter int N = 8
) (
    input logic                CLK,
    input logic                RST,
    prio_encoder_pipe_if.slave bus
);
    localparam int W = calc_w(N);
    localparam logic [W-1:0] LAST = W'(N - 1);

    logic [N-1:0] s1_req_q, s1_req_d;
    logic         s1_rr_q, s1_rr_d;
    logic         s1_v_q, s1_v_d;
    logic         s2_v_q, s2_v_d;
    logic [W-1:0] out_idx_q, out_idx_d;
    logic         out_none_q, out_none_d;
    logic [W-1:0] ptr_q, ptr_d;

    logic         s2_free, rdy_enc, take, advance;
    logic [W-1:0] core_idx;
    logic         core_none;

    prio_enc_core #(.N(N), .W(W)) u_core (
        .req     (s1_req_q),
        .ptr     (ptr_q),
        .mode_rr (s1_rr_q),
        .idx     (core_idx),
        .none    (core_none)
    );

    always_comb begin
        s2_free = !s2_v_q || bus.EN_out;
        rdy_enc = !s1_v_q || s2_free;
        take    = bus.EN_enc && rdy_enc;
        advance = s1_v_q && s2_free;

        s1_req_d   = s1_req_q;
        s1_rr_d    = s1_rr_q;
        s2_v_d     = s2_v_q;
        out_idx_d  = out_idx_q;
        out_none_d = out_none_q;
        ptr_d      = ptr_q;

        if (take) begin
            s1_req_d = bus.enc_req;
            s1_rr_d  = bus.enc_mode_rr;
        end
        s1_v_d = take || (s1_v_q && !advance);

        // The pointer moves only past a real round-robin winner; empty requests leave it alone.
        if (advance) begin
            s2_v_d     = 1'b1;
            out_idx_d  = core_idx;
            out_none_d = core_none;
            if (s1_rr_q == MODE_RR && !core_none)
                ptr_d = (core_idx == LAST) ? '0 : core_idx + W'(1);
        end else if (s2_v_q && bus.EN_out) begin
            s2_v_d = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            s1_req_q   <= '0;
            s1_rr_q    <= 1'b0;
            s1_v_q     <= 1'b0;
            s2_v_q     <= 1'b0;
            out_idx_q  <= '0;
            out_none_q <= 1'b0;
            ptr_q      <= '0;
        end else begin
            s1_req_q   <= s1_req_d;
            s1_rr_q    <= s1_rr_d;
            s1_v_q     <= s1_v_d;
            s2_v_q     <= s2_v_d;
            out_idx_q  <= out_idx_d;
            out_none_q <= out_none_d;
            ptr_q      <= ptr_d;
        end
    end

    assign bus.RDY_enc  = rdy_enc;
    assign bus.RDY_out  = s2_v_q;
    assign bus.out_idx  = out_idx_q;
    assign bus.out_none = out_none_q;

endmodule

// File: tb/tb_prio_encoder_pipe.sv
// Bench for prio_encoder_pipe: directed scenarios plus random traffic on an N=8 and an
// N=5 instance, each scored against an in-order queue of expected results.
module tb_prio_encoder_pipe;

    logic clk;
    logic rst;

    prio_encoder_pipe_if #(.N(8)) if8 ();
    prio_encoder_pipe_if #(.N(5)) if5 ();

    prio_encoder_pipe #(.N(8)) dut8 (.CLK(clk), .RST(rst), .bus(if8));
    prio_encoder_pipe #(.N(5)) dut5 (.CLK(clk), .RST(rst), .bus(if5));

    int n_checks = 0;
    int n_pass   = 0;
    int q8[$];
    int q5[$];
    int obs8[$];
    int obs5[$];
    int ptr8 = 0;
    int ptr5 = 0;
    bit hold_v = 0;
    int hold_code = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input int observed, input int expected);
        n_checks++;
        if (observed == expected) n_pass++;
        else $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    endtask

    // Result code: winning index, or 1000 for an all-zero request.
    function automatic int ref_encode(input logic [255:0] req, input int n, input bit rr, inout int ptr);
        int j;
        if (rr) begin
            for (int k = 0; k < n; k++) begin
                j = (ptr + k) % n;
                if (req[j]) begin
                    ptr = (j + 1) % n;
                    return j;
                end
            end
        end else begin
            for (int i = n - 1; i >= 0; i--) if (req[i]) return i;
        end
        return 1000;
    endfunction

    task automatic observe8();
        int got;
        if (rst) begin
            q8.delete();
            ptr8   = 0;
            hold_v = 0;
            return;
        end
        got = int'(if8.out_idx) + 1000 * int'(if8.out_none);
        if (hold_v) checkOutput("hold8", got + 10000 * int'(if8.RDY_out), hold_code);
        checkOutput("rdy_enc8", int'(if8.RDY_enc), int'((q8.size() < 2) || if8.EN_out));
        hold_v    = if8.RDY_out && !if8.EN_out;
        hold_code = got + 10000 * int'(if8.RDY_out);
        if (if8.EN_out && if8.RDY_out) begin
            checkOutput("pending8", int'(q8.size() > 0), 1);
            if (q8.size() > 0) checkOutput("result8", got, q8.pop_front());
            obs8.push_back(got);
        end
        if (if8.EN_enc && if8.RDY_enc)
            q8.push_back(ref_encode(256'(if8.enc_req), 8, if8.enc_mode_rr, ptr8));
    endtask

    task automatic observe5();
        int got;
        if (rst) begin
            q5.delete();
            ptr5 = 0;
            return;
        end
        got = int'(if5.out_idx) + 1000 * int'(if5.out_none);
        checkOutput("rdy_enc5", int'(if5.RDY_enc), int'((q5.size() < 2) || if5.EN_out));
        if (if5.EN_out && if5.RDY_out) begin
            checkOutput("pending5", int'(q5.size() > 0), 1);
            if (q5.size() > 0) checkOutput("result5", got, q5.pop_front());
            obs5.push_back(got);
        end
        if (if5.EN_enc && if5.RDY_enc)
            q5.push_back(ref_encode(256'(if5.enc_req), 5, if5.enc_mode_rr, ptr5));
    endtask

    task automatic tickCycle();
        @(negedge clk);
        observe8();
        observe5();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input bit en, input logic [7:0] req, input bit rr, input bit en_out);
        if8.EN_enc      = en;
        if8.enc_req     = req;
        if8.enc_mode_rr = rr;
        if8.EN_out      = en_out;
        tickCycle();
    endtask

    task automatic applyStimulus5(input bit en, input logic [4:0] req, input bit rr, input bit en_out);
        if5.EN_enc      = en;
        if5.enc_req     = req;
        if5.enc_mode_rr = rr;
        if5.EN_out      = en_out;
        tickCycle();
    endtask

    task automatic drainAll();
        if8.EN_enc = 1'b0;
        if8.EN_out = 1'b1;
        if5.EN_enc = 1'b0;
        if5.EN_out = 1'b1;
        for (int i = 0; i < 10 && (q8.size() + q5.size()) > 0; i++) tickCycle();
        tickCycle();
        checkOutput("drain_q8", q8.size(), 0);
        checkOutput("drain_q5", q5.size(), 0);
        checkOutput("drain_rdy_out8", int'(if8.RDY_out), 0);
        checkOutput("drain_rdy_out5", int'(if5.RDY_out), 0);
    endtask

    task automatic checkObs(input string tag, input bit use5, input int n, input int exp_codes [8]);
        int got;
        checkOutput({tag, "_count"}, use5 ? obs5.size() : obs8.size(), n);
        for (int i = 0; i < n; i++) begin
            got = -1;
            if (use5 && i < obs5.size()) got = obs5[i];
            if (!use5 && i < obs8.size()) got = obs8[i];
            checkOutput($sformatf("%s_%0d", tag, i), got, exp_codes[i]);
        end
    endtask

    initial begin
        int e[8];

        rst             = 1'b1;
        if8.EN_enc      = 1'b0;
        if8.enc_req     = '0;
        if8.enc_mode_rr = 1'b0;
        if8.EN_out      = 1'b1;
        if5.EN_enc      = 1'b0;
        if5.enc_req     = '0;
        if5.enc_mode_rr = 1'b0;
        if5.EN_out      = 1'b1;
        repeat (2) tickCycle();
        rst = 1'b0;

        checkOutput("rst_rdy_out", int'(if8.RDY_out), 0);
        checkOutput("rst_out_idx", int'(if8.out_idx), 0);
        checkOutput("rst_out_none", int'(if8.out_none), 0);
        checkOutput("rst_rdy_enc", int'(if8.RDY_enc), 1);
        checkOutput("rst_rdy_out5", int'(if5.RDY_out), 0);

        // Fixed priority back-to-back with two-cycle latency.
        applyStimulus(1'b1, 8'h20, 1'b0, 1'b1);
        checkOutput("t1_rdy_out_early", int'(if8.RDY_out), 0);
        applyStimulus(1'b1, 8'h81, 1'b0, 1'b1);
        checkOutput("t1_rdy_out_a", int'(if8.RDY_out), 1);
        checkOutput("t1_idx_a", int'(if8.out_idx), 5);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
        checkOutput("t1_rdy_out_b", int'(if8.RDY_out), 1);
        checkOutput("t1_idx_b", int'(if8.out_idx), 7);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
        checkOutput("t1_rdy_out_idle", int'(if8.RDY_out), 0);

        // Round-robin sweep from a fresh pointer.
        rst = 1'b1;
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
        rst = 1'b0;
        obs8.delete();
        repeat (4) applyStimulus(1'b1, 8'hFF, 1'b1, 1'b1);
        applyStimulus(1'b1, 8'h01, 1'b1, 1'b1);
        drainAll();
        e = '{0, 1, 2, 3, 0, 0, 0, 0};
        checkObs("t2", 1'b0, 5, e);

        // Zero requests in both modes must not disturb the pointer (left at 1).
        obs8.delete();
        applyStimulus(1'b1, 8'h00, 1'b1, 1'b1);
        applyStimulus(1'b1, 8'h00, 1'b0, 1'b1);
        applyStimulus(1'b1, 8'hFF, 1'b1, 1'b1);
        drainAll();
        e = '{1000, 1000, 1, 0, 0, 0, 0, 0};
        checkObs("t3", 1'b0, 3, e);

        // Backpressure: only two requests fit while the consumer stalls.
        obs8.delete();
        for (int k = 0; k < 5; k++) applyStimulus(1'b1, 8'(1 << k), 1'b0, 1'b0);
        checkOutput("t4_accepted", q8.size(), 2);
        checkOutput("t4_rdy_enc", int'(if8.RDY_enc), 0);
        checkOutput("t4_held_idx", int'(if8.out_idx), 0);
        drainAll();
        e = '{0, 1, 0, 0, 0, 0, 0, 0};
        checkObs("t4", 1'b0, 2, e);

        // Reset with both stages full drops everything and rewinds the pointer.
        applyStimulus(1'b1, 8'hFF, 1'b1, 1'b0);
        applyStimulus(1'b1, 8'hFF, 1'b1, 1'b0);
        checkOutput("t5_full_rdy_enc", int'(if8.RDY_enc), 0);
        rst = 1'b1;
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        rst = 1'b0;
        checkOutput("t5_rdy_out", int'(if8.RDY_out), 0);
        checkOutput("t5_out_idx", int'(if8.out_idx), 0);
        checkOutput("t5_rdy_enc", int'(if8.RDY_enc), 1);
        obs8.delete();
        applyStimulus(1'b1, 8'hFF, 1'b1, 1'b1);
        drainAll();
        e = '{0, 0, 0, 0, 0, 0, 0, 0};
        checkObs("t5", 1'b0, 1, e);

        // Non-power-of-two width: pointer wraps from 4 back to 0.
        obs5.delete();
        repeat (4) applyStimulus5(1'b1, 5'b10001, 1'b1, 1'b1);
        applyStimulus5(1'b1, 5'b10001, 1'b0, 1'b1);
        drainAll();
        e = '{0, 4, 0, 4, 4, 0, 0, 0};
        checkObs("t6", 1'b1, 5, e);

        // Random traffic on both instances with random stalls and mixed modes.
        for (int c = 0; c < 400; c++) begin
            if8.EN_enc      = ($urandom_range(0, 9) < 7);
            if8.enc_req     = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
            if8.enc_mode_rr = 1'($urandom);
            if8.EN_out      = ($urandom_range(0, 9) < 6);
            if5.EN_enc      = ($urandom_range(0, 9) < 7);
            if5.enc_req     = ($urandom_range(0, 7) == 0) ? 5'h00 : 5'($urandom);
            if5.enc_mode_rr = 1'($urandom);
            if5.EN_out      = ($urandom_range(0, 9) < 6);
            tickCycle();
        end
        drainAll();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
